// File: rtl/mic_seq_pkg.sv
// mic_seq_pkg: shared state encoding and widths for the microphone sample sequencer
package mic_seq_pkg;
  typedef enum logic [1:0] {IDLE, START, WAIT} state_t;
  localparam int ADC_W = 12;
  localparam int PWM_W = 8;
  localparam int AVG_N = 4;
  localparam int ACC_W = 14;
endpackage

// File: rtl/sample_tick_gen.sv
// sample_tick_gen: divides clk by TICK_DIV into a one-cycle tick, held at 0 while en is low
module sample_tick_gen #(
  parameter int TICK_DIV = 2500
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);
  logic [15:0] cnt;
  assign tick = en && cnt == 16'(TICK_DIV - 1);
  // free-running divider, wraps on tick and parks at 0 when disabled
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else cnt <= (!en || tick) ? '0 : cnt + 16'd1;
endmodule

// File: rtl/mic_sample_sequencer.sv
// mic_sample_sequencer: sample-rate START/DONE sequencing and capture for PmodMIC; define MIC_SEQ_AVG_EN to publish 4-capture averages
module mic_sample_sequencer
  import mic_seq_pkg::*;
#(
  parameter int TICK_DIV = 2500,
  parameter int TIMEOUT  = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr_err,
  output logic             start,
  input  logic             done,
  input  logic [ADC_W-1:0] adc_data,
  output logic [ADC_W-1:0] sample,
  output logic             sample_valid,
  output logic [PWM_W-1:0] pwm_val,
  output logic             overrun,
  output logic             timeout
);
  state_t state;
  logic tick;
  logic [15:0] tcnt;
`ifdef MIC_SEQ_AVG_EN
  logic [ACC_W-1:0] acc, sum;
  logic [1:0] acnt;
  assign sum = acc + ACC_W'(adc_data);
`endif
  sample_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk(clk),
    .rst(rst),
    .en(en),
    .tick(tick)
  );
  assign pwm_val = sample[ADC_W-1:ADC_W-PWM_W];
  // handshake FSM with timeout counter, sticky flags (set beats clear) and capture
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      start <= 1'b0;
      tcnt <= '0;
      sample <= '0;
      sample_valid <= 1'b0;
      overrun <= 1'b0;
      timeout <= 1'b0;
`ifdef MIC_SEQ_AVG_EN
      acc <= '0;
      acnt <= '0;
`endif
    end else begin
      start <= 1'b0;
      sample_valid <= 1'b0;
      overrun <= (tick && state != IDLE) || (overrun && !clr_err);
      timeout <= (state == WAIT && !done && tcnt == 16'(TIMEOUT - 1)) || (timeout && !clr_err);
      case (state)
        IDLE: if (tick) begin
          state <= START;
          start <= 1'b1;
        end
        START: begin
          state <= WAIT;
          tcnt <= '0;
        end
        WAIT: if (done) begin
          state <= IDLE;
`ifdef MIC_SEQ_AVG_EN
          acc <= (acnt == 2'(AVG_N - 1)) ? '0 : sum;
          acnt <= acnt + 2'd1;
          if (acnt == 2'(AVG_N - 1)) begin
            sample <= sum[ACC_W-1:2];
            sample_valid <= 1'b1;
          end
`else
          sample <= adc_data;
          sample_valid <= 1'b1;
`endif
        end else if (tcnt == 16'(TIMEOUT - 1)) state <= IDLE;
        else tcnt <= tcnt + 16'd1;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_mic_sample_sequencer.sv
// tb_mic_sample_sequencer: directed + randomized checks of mic_sample_sequencer against a transaction-level model
module tb_mic_sample_sequencer;
  logic clk = 0, rst = 1, en = 0, clr_err = 0, done = 0;
  logic [11:0] adc_data = 0, sample;
  logic [7:0] pwm_val;
  logic start, sample_valid, overrun, timeout;
  int checks = 0, passes = 0, fails = 0, nstart = 0, nvalid = 0, exp_nvalid = 0;
  logic [11:0] m_sample = 0;
  logic m_valid;
  int q[$];

  always #5 clk = ~clk;

  mic_sample_sequencer #(.TICK_DIV(10), .TIMEOUT(16)) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .clr_err(clr_err),
    .start(start),
    .done(done),
    .adc_data(adc_data),
    .sample(sample),
    .sample_valid(sample_valid),
    .pwm_val(pwm_val),
    .overrun(overrun),
    .timeout(timeout)
  );

  always @(posedge clk) begin
    if (start) nstart <= nstart + 1;
    if (sample_valid) nvalid <= nvalid + 1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, expected finish before 100us");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Published value per capture: the capture itself, or the mean of each group of four.
  task automatic model_capture(input logic [11:0] d);
`ifdef MIC_SEQ_AVG_EN
    int s;
    s = 0;
    m_valid = 0;
    q.push_back(int'(d));
    if (q.size() == 4) begin
      foreach (q[i]) s += q[i];
      m_sample = 12'(s / 4);
      m_valid = 1;
      q.delete();
    end
`else
    m_sample = d;
    m_valid = 1;
`endif
    if (m_valid) exp_nvalid++;
  endtask

  task automatic wait_start(input string tag, input int exp);
    int w;
    w = 0;
    while (start !== 1'b1 && w < 40) begin
      @(negedge clk);
      w++;
    end
    chk(tag, w, exp);
  endtask

  // Called at the negedge where start is seen; done lands d cycles later.
  task automatic conv(input string tag, input int d, input logic [11:0] data);
    repeat (d) @(negedge clk);
    done = 1;
    adc_data = data;
    @(negedge clk);
    done = 0;
    adc_data = 12'($urandom);
    model_capture(data);
    chk({tag, "_valid"}, sample_valid, m_valid);
    chk({tag, "_sample"}, sample, m_sample);
    chk({tag, "_pwm"}, pwm_val, m_sample[11:4]);
  endtask

  initial begin
    int d, ns;
    repeat (3) @(negedge clk);
    chk("rst_start", start, 0);
    chk("rst_sample", sample, 0);
    chk("rst_valid", sample_valid, 0);
    chk("rst_pwm", pwm_val, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_timeout", timeout, 0);
    rst = 0;
    en = 1;
    wait_start("first_start", 10);
    conv("a0", 5, 12'hA5C);
    chk("a0_overrun", overrun, 0);
    wait_start("a0_period", 4);
    for (int i = 1; i < 8; i++) begin
      d = (i == 1) ? 8 : (i == 2) ? 1 : $urandom_range(8, 1);
      conv("a", d, 12'($urandom));
      chk("a_overrun", overrun, 0);
      wait_start("a_period", 9 - d);
    end
    ns = nstart;
    repeat (9) @(negedge clk);
    clr_err = 1;
    @(negedge clk);
    clr_err = 0;
    chk("b_set_wins", overrun, 1);
    conv("b", 2, 12'($urandom));
    chk("b_overrun_sticky", overrun, 1);
    clr_err = 1;
    @(negedge clk);
    clr_err = 0;
    chk("b_clr", overrun, 0);
    wait_start("b_next", 6);
    chk("b_dropped_tick", nstart - ns, 1);
    ns = nvalid;
    repeat (16) @(negedge clk);
    chk("c_not_yet", timeout, 0);
    @(negedge clk);
    chk("c_timeout", timeout, 1);
    chk("c_overrun", overrun, 1);
    clr_err = 1;
    @(negedge clk);
    clr_err = 0;
    chk("c_clr_timeout", timeout, 0);
    chk("c_clr_overrun", overrun, 0);
    chk("c_no_valid", nvalid - ns, 0);
    wait_start("c_next", 2);
    conv("c_after", 3, 12'($urandom));
    wait_start("c_after_period", 6);
    ns = nvalid;
    repeat (2) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    done = 1;
    adc_data = 12'hFFF;
    @(negedge clk);
    done = 0;
    q.delete();
    m_sample = 0;
    chk("d_start", start, 0);
    chk("d_sample", sample, 0);
    chk("d_valid", sample_valid, 0);
    chk("d_pwm", pwm_val, 0);
    chk("d_overrun", overrun, 0);
    chk("d_timeout", timeout, 0);
    wait_start("d_resume", 9);
    chk("d_no_valid", nvalid - ns, 0);
    conv("avg0", 4, 12'd100);
    wait_start("avg0_period", 5);
    conv("avg1", 4, 12'd200);
    wait_start("avg1_period", 5);
    conv("avg2", 4, 12'd300);
    wait_start("avg2_period", 5);
    conv("avg3", 4, 12'd401);
`ifdef MIC_SEQ_AVG_EN
    chk("avg_result", sample, 250);
`else
    chk("avg_result", sample, 401);
`endif
    wait_start("avg3_period", 5);
    @(negedge clk);
    en = 0;
    conv("e", 3, 12'($urandom));
    ns = nstart;
    repeat (30) @(negedge clk);
    chk("e_no_start", nstart - ns, 0);
    en = 1;
    wait_start("e_reenable", 10);
    conv("e_min_latency", 1, 12'($urandom));
    repeat (3) @(negedge clk);
    chk("valid_count", nvalid, exp_nvalid);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/mic_sample_sequencer.md
# mic_sample_sequencer

Sequencer for the microphone ADC path. It generates the audio sample rate, drives the START/DONE handshake of the PmodMIC SPI controller, and captures each 12-bit result into a holding register. It publishes a one-cycle sample strobe and an 8-bit value for the PWM/LED path, and flags overruns and lost conversions. It sits between the top level and the PmodMIC controller and replaces the ad-hoc sample-clock state logic.

## Interface
- TICK_DIV, 2500: clk cycles per sample tick (40 kHz at 100 MHz); legal range 4..65535.
- TIMEOUT, 1024: max clk cycles in WAIT before a conversion is declared lost; legal range 2..65535.
- clk  in  1  system clock; one clock domain.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  enables tick generation; the tick counter is held at 0 while low.
- clr_err  in  1  clears `overrun` and `timeout`.
- start  out  1  one-cycle conversion request to the PmodMIC controller.
- done  in  1  conversion-complete pulse from the PmodMIC controller.
- adc_data  in  12  conversion result; valid in the cycle `done`=1.
- sample  out  12  last captured or averaged sample.
- sample_valid  out  1  one-cycle strobe; `sample` is updated in the same cycle.
- pwm_val  out  8  sample[11:4].
- overrun  out  1  sticky: a tick arrived while the sequencer was busy.
- timeout  out  1  sticky: a conversion got no `done` within TIMEOUT cycles.

## Operation
- Reset values: all outputs 0; state IDLE; tick counter, timeout counter and accumulator 0.
- Tick counter: counts 0..TICK_DIV-1 while `en`=1. `tick` is high when count = TICK_DIV-1, then the counter wraps to 0.
- State machine:
  - IDLE: on `tick` → START. `done` is ignored in IDLE.
  - START: `start`=1 (Moore output) → WAIT. The timeout counter is cleared.
  - WAIT: on `done`=1 → register `adc_data`, go to IDLE. Otherwise the timeout counter increments. When it reaches TIMEOUT-1 → set `timeout`, go to IDLE, no capture.
- Overrun: `tick` while state ≠ IDLE sets `overrun`. The tick is dropped, not queued. This includes a tick in the same cycle as `done`.
- `en` falling mid-conversion: the current conversion completes normally and no new ticks occur.
- `clr_err` clears both sticky flags. If a set condition and `clr_err` occur in the same cycle, the set wins.
- `pwm_val` always equals `sample[11:4]` and updates with `sample`.

## Timing
- Tick in cycle T (IDLE) → `start`=1 in cycle T+1 only.
- `done` in cycle D (WAIT) → `sample` and `sample_valid` in cycle D+1. The sequencer is back in IDLE at D+1 and can accept a tick in that same cycle.
- With no timeout, the minimum tick-to-strobe latency is 3 cycles (`done` arriving the cycle after `start`).
- `rst` mid-conversion: the sequencer returns to IDLE immediately. A late `done` arriving afterwards is ignored.

## Configuration
- MIC_SEQ_AVG_EN defined:
  - Captures accumulate in a 14-bit register.
  - Every 4th capture, `sample` = (sum of 4) >> 2, `sample_valid` pulses, and the accumulator and a 2-bit capture count clear.
  - Lost (timeout) conversions do not advance the count.
- MIC_SEQ_AVG_EN undefined: every capture is published directly, and no accumulator is instantiated.

## Structure
- Package mic_seq_pkg:
  - state enum (IDLE, START, WAIT);
  - ADC_W=12, PWM_W=8, AVG_N=4, ACC_W=14.
- Sub-module sample_tick_gen: the parameterised TICK_DIV counter with `en` and a `tick` output. The FSM, timeout counter, flags and accumulator live in mic_sample_sequencer.

## Test plan
- TICK_DIV=10, en=1, `done` returned 5 cycles after each `start` with adc_data=12'hA5C:
  - `start` every 10 cycles;
  - `sample`=12'hA5C and `pwm_val`=8'hA5 one cycle after each `done`;
  - `overrun`=0.
- TICK_DIV=10, `done` delayed 12 cycles after `start`: the next tick sets `overrun`=1; exactly one `sample_valid` per two ticks.
- TIMEOUT=16, `done` never asserted: `timeout`=1 sixteen cycles after entering WAIT, FSM back in IDLE, no `sample_valid`. Pulsing `clr_err` clears it.
- `rst` asserted two cycles after `start`, then a spurious `done`: all outputs 0, no `sample_valid`. Normal sequencing resumes at the next tick.
- MIC_SEQ_AVG_EN defined, captures 100, 200, 300, 401: exactly one `sample_valid`, after the 4th capture, with `sample`=250.
- `en` dropped during WAIT: the conversion completes with one `sample_valid`, then no `start` while `en`=0.
